// File: rtl/serial_async_receiver.sv
// serial_async_receiver: 8N1 UART receiver with oversampled glitch filter, idle and end-of-packet detection.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_async_receiver #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_frame_error,
    output logic       RxD_parity_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);
    localparam int              PW      = $clog2(Oversampling);
    localparam int              GW      = $clog2(2 * Oversampling + 1);
    localparam logic [31:0]     INC     = 32'(Baud * Oversampling);
    localparam logic [31:0]     CLKF    = 32'(ClkFrequency);
    localparam logic [PW-1:0]   MID     = PW'(Oversampling / 2 - 1);
    localparam logic [GW-1:0]   GAP_MAX = GW'(2 * Oversampling);

    if (ClkFrequency < Baud * Oversampling) begin : g_bad_clk
        $error("serial_async_receiver: ClkFrequency must be >= Baud*Oversampling");
    end
    if (Oversampling != 4 && Oversampling != 8 && Oversampling != 16) begin : g_bad_os
        $error("serial_async_receiver: Oversampling must be 4, 8 or 16");
    end

    typedef enum logic [3:0] {
        IDLE, START, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7,
`ifdef SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP, WAIT_HIGH
    } state_t;

    logic [31:0]   acc_q, acc_d, acc_sum;
    logic          tick_q, tick_d;
    logic [1:0]    sync_q, sync_d, filt_q, filt_d;
    logic          bit_q, bit_d;
    logic [PW-1:0] phase_q, phase_d;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          ready_q, ready_d, ferr_q, ferr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          idle_q, idle_d, eop_q, eop_d, seen_q, seen_d;
    logic          sample_now;
`ifdef SERIAL_RX_PARITY_EN
    logic          par_q, par_d, perr_q, perr_d;
`endif

    always_comb begin
        acc_sum    = acc_q + INC;
        tick_d     = acc_sum >= CLKF;
        acc_d      = tick_d ? acc_sum - CLKF : acc_sum;
        sync_d     = {sync_q[0], RxD};
        filt_d     = !tick_q ? filt_q :
                     sync_q[1] ? (filt_q == 2'd3 ? filt_q : filt_q + 2'd1) :
                                 (filt_q == 2'd0 ? filt_q : filt_q - 2'd1);
        bit_d      = filt_d == 2'd3 ? 1'b1 : filt_d == 2'd0 ? 1'b0 : bit_q;
        phase_d    = !tick_q ? phase_q : state_q == IDLE ? '0 : phase_q + PW'(1);
        sample_now = tick_q && state_q != IDLE && phase_q == MID;
        state_d    = state_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE:      if (tick_q && !bit_q) state_d = START;
            START:     if (sample_now) state_d = bit_q ? IDLE : BIT0;
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7:
                if (sample_now) begin
                    shift_d = {bit_q, shift_q[7:1]};
                    state_d = state_t'(state_q + 4'd1);
                end
`ifdef SERIAL_RX_PARITY_EN
            PARITY:
                if (sample_now) begin
                    par_d   = ^{shift_q, bit_q};
                    state_d = STOP;
                end
`endif
            STOP:
                if (sample_now) begin
                    state_d = bit_q ? IDLE : WAIT_HIGH;
                    ready_d = bit_q;
                    ferr_d  = !bit_q;
                    data_d  = bit_q ? shift_q : data_q;
`ifdef SERIAL_RX_PARITY_EN
                    perr_d  = bit_q && par_q;
`endif
                end
            WAIT_HIGH: if (tick_q && bit_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        gap_d  = (state_q != IDLE || !bit_q) ? '0 : (tick_q && gap_q != GAP_MAX) ? gap_q + GW'(1) : gap_q;
        idle_d = gap_d == GAP_MAX;
        eop_d  = idle_d && !idle_q && seen_q;
        seen_d = eop_d ? 1'b0 : ready_d ? 1'b1 : seen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            tick_q  <= 1'b0;
            sync_q  <= 2'b11;
            filt_q  <= 2'd3;
            bit_q   <= 1'b1;
            phase_q <= '0;
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            gap_q   <= '0;
            idle_q  <= 1'b0;
            eop_q   <= 1'b0;
            seen_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            tick_q  <= tick_d;
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            gap_q   <= gap_d;
            idle_q  <= idle_d;
            eop_q   <= eop_d;
            seen_q  <= seen_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign RxD_data_ready  = ready_q;
    assign RxD_data        = data_q;
    assign RxD_frame_error = ferr_q;
    assign RxD_idle        = idle_q;
    assign RxD_endofpacket = eop_q;
`ifdef SERIAL_RX_PARITY_EN
    assign RxD_parity_error = perr_q;
`else
    assign RxD_parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_serial_async_receiver.sv
// tb_serial_async_receiver: scoreboard bench; frames are queued as expected outcomes, a monitor checks each strobe.
module tb_serial_async_receiver;
    logic       clk = 1'b0, rst_n = 1'b0, RxD = 1'b1;
    logic       ready, ferr, perr, idle, eop;
    logic [7:0] data;

`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BIT_CLK = 16;

    serial_async_receiver #(.ClkFrequency(1843200), .Baud(115200), .Oversampling(8)) dut (
        .clk(clk), .rst_n(rst_n), .RxD(RxD),
        .RxD_data_ready(ready), .RxD_data(data), .RxD_frame_error(ferr),
        .RxD_parity_error(perr), .RxD_idle(idle), .RxD_endofpacket(eop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0, failures = 0, eop_cnt = 0, base;
    logic [7:0] last_data = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bitv(input logic v, input int n);
        #1 RxD = v;
        repeat (n) @(posedge clk);
    endtask

    // A frame is judged by line rules alone: stop high delivers data, stop low is a framing error,
    // and with parity the nine bits must hold an even number of ones.
    task automatic send(input logic [7:0] d, input logic p, input int stop_low);
        exp_t e;
        e.fe = stop_low > 0;
        e.d  = d;
        e.pe = PAR && !e.fe && (^{d, p});
        sb.push_back(e);
        bitv(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) bitv(d[i], BIT_CLK);
        if (PAR) bitv(p, BIT_CLK);
        if (stop_low > 0) bitv(1'b0, BIT_CLK * stop_low);
        bitv(1'b1, BIT_CLK);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ready || ferr) begin
                if (sb.size() == 0) chk("unexpected_strobe", int'({ready, ferr}), 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind", int'({ferr, ready}), int'({mon_e.fe, !mon_e.fe}));
                    if (!mon_e.fe) last_data = mon_e.d;
                    chk("rx_data", int'(data), int'(last_data));
                    chk("parity_error", int'(perr), int'(mon_e.pe));
                end
            end else if (perr) chk("stray_parity_error", int'(perr), 0);
            if (eop) eop_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] f, d;
        logic       p;
        int         sl;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data", int'(data), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_ferr", int'(ferr), 0);
        chk("reset_idle", int'(idle), 0);
        chk("reset_eop", int'(eop), 0);
        rst_n = 1'b1;
        bitv(1'b1, 60);
        #2;
        chk("idle_after_reset", int'(idle), 1);
        chk("no_eop_without_byte", eop_cnt, 0);

        send(8'h55, 1'b1, 0);
        send(8'hA3, 1'b0, 0);
        bitv(1'b1, 100);
        #2 chk("back_to_back_drained", sb.size(), 0);

        bitv(1'b0, 6);
        bitv(1'b1, 100);
        #2 chk("glitch_data_hold", int'(data), int'(last_data));

        send(8'h3C, 1'b0, 3);
        send(8'h81, 1'b0, 0);
        bitv(1'b1, 100);
        #2 chk("break_then_byte_drained", sb.size(), 0);

        base = eop_cnt;
        send(8'h12, 1'b0, 0);
        #2 chk("idle_low_after_frame", int'(idle), 0);
        bitv(1'b1, 100);
        #2 chk("idle_after_gap", int'(idle), 1);
        chk("eop_once", eop_cnt, base + 1);
        bitv(1'b1, 200);
        #2 chk("eop_no_repeat", eop_cnt, base + 1);

        f = 8'hF0;
        bitv(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) bitv(f[i], BIT_CLK);
        bitv(f[4], 8);
        #1 rst_n = 1'b0;
        RxD = 1'b1;
        last_data = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        chk("midframe_reset_data", int'(data), 0);
        chk("midframe_reset_ready", int'(ready), 0);
        chk("midframe_reset_idle", int'(idle), 0);
        rst_n = 1'b1;
        bitv(1'b1, 60);
        send(8'h0F, 1'b0, 0);
        bitv(1'b1, 100);
        #2 chk("after_reset_drained", sb.size(), 0);
        chk("after_reset_data", int'(data), 8'h0F);

        send(8'h07, 1'b0, 0);
        send(8'h07, 1'b1, 0);
        bitv(1'b1, 60);

        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            sl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(d, p, sl);
            bitv(1'b1, sl > 0 ? BIT_CLK : int'($urandom_range(0, 40)));
        end

        for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
        #2 chk("final_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
